// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the wait-state memory responder:
// FSM state encoding, default bus widths and the wait-counter width.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 9;
    localparam int WAIT_MAX       = 15;
    localparam int CNT_W          = $clog2(WAIT_MAX + 1);

endpackage

// File: rtl/ram_array_sp.sv
// Single-port synchronous RAM: write on en&we, registered read on en&~we.
// Only the read register is cleared; array contents survive a clear.
module ram_array_sp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (en && we)
            mem[addr] <= wdata;
    end

    // Read register holds the last read value until the next read.
    always_ff @(posedge clk) begin
        if (clear)
            rdata <= '0;
        else if (en && !we)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_responder_512x32.sv
// Wait-state memory responder: one request at a time, optional wait cycles,
// one-cycle mem_ready pulse. Wait states are built only with MEM_WAITSTATE_EN.
module mem_responder_512x32
    import mem_bus_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int WAIT_STATES = 2
) (
    input  logic                  Clock,
    input  logic                  clear,
    input  logic                  Mem_read,
    input  logic                  Mem_write,
    input  logic                  Mem_enable,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  mem_ready,
    output logic                  busy,
    output logic                  proto_err
);

    if (WAIT_STATES < 0 || WAIT_STATES > WAIT_MAX) begin : g_ws_range
        $error("WAIT_STATES must be in 0..15");
    end

    state_t                state;
    logic                  req_valid;
    logic                  req_conflict;
    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;

    assign req_valid    = Mem_enable & (Mem_read ^ Mem_write);
    assign req_conflict = Mem_enable & Mem_read & Mem_write;

`ifdef MEM_WAITSTATE_EN
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);

    logic [CNT_W-1:0]      cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  write_q;

    // Access fires on the last WAIT edge using only the latched request.
    assign ram_en    = (state == WAIT) && (cnt == '0) && !clear;
    assign ram_we    = write_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = data_q;

    always_ff @(posedge Clock) begin
        if (clear) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            write_q   <= 1'b0;
            mem_ready <= 1'b0;
            busy      <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mem_ready <= 1'b0;
                    if (req_valid) begin
                        addr_q  <= address;
                        data_q  <= data_in;
                        write_q <= Mem_write;
                        cnt     <= WAIT_INIT;
                        busy    <= 1'b1;
                        state   <= WAIT;
                    end else if (req_conflict) begin
                        proto_err <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        mem_ready <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    mem_ready <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    mem_ready <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
`else
    // No wait states: the array is accessed on the accepting edge itself.
    assign ram_en    = (state == IDLE) && req_valid && !clear;
    assign ram_we    = Mem_write;
    assign ram_addr  = address;
    assign ram_wdata = data_in;

    always_ff @(posedge Clock) begin
        if (clear) begin
            state     <= IDLE;
            mem_ready <= 1'b0;
            busy      <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mem_ready <= 1'b0;
                    if (req_valid) begin
                        mem_ready <= 1'b1;
                        busy      <= 1'b1;
                        state     <= RESP;
                    end else if (req_conflict) begin
                        proto_err <= 1'b1;
                    end
                end
                default: begin
                    mem_ready <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
`endif

    ram_array_sp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (Clock),
        .clear (clear),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (data_out)
    );

endmodule
